// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;
    localparam int DIV_ITERS  = DIV_DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q}, trial-subtract |y|, set quotient bit.
// Latency: combinational.
// Backpressure: none.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] dvsr,
    output logic [DATA_W:0]   rem_nxt,
    output logic [DATA_W-1:0] quo_nxt
);

    logic [DATA_W:0]   sh;
    logic [DATA_W+1:0] diff;
    logic              ge;

    assign sh   = {rem[DATA_W-1:0], quo[DATA_W-1]};
    assign diff = {1'b0, sh} - {2'b00, dvsr};
    // A set top bit of R means the shifted value already exceeds any divisor.
    assign ge   = rem[DATA_W] | ~diff[DATA_W+1];

    assign rem_nxt = ge ? diff[DATA_W:0] : sh;
    assign quo_nxt = {quo[DATA_W-2:0], ge};

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (signed/unsigned) serving the EXE stage.
// Latency: result valid 33 cycles after the request is accepted; held until out_ack.
// Backpressure: holds complete/s/r in DONE until out_ack; a low div or cancel aborts.
module div_iter
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cancel_exc_ertn,
    input  logic              div,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              out_ack,
    output logic [DATA_W-1:0] s,
    output logic [DATA_W-1:0] r,
    output logic              complete,
    output logic              busy
);

    div_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] yabs;
    logic              sq;
    logic              sr;

    logic [DATA_W:0]   rem_nxt;
    logic [DATA_W-1:0] quo_nxt;
    logic [DATA_W-1:0] xabs_in;
    logic [DATA_W-1:0] yabs_in;
    logic              xneg;
    logic              yneg;

    assign xneg    = div_signed & x[DATA_W-1];
    assign yneg    = div_signed & y[DATA_W-1];
    assign xabs_in = xneg ? -x : x;
    assign yabs_in = yneg ? -y : y;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem     (rem),
        .quo     (quo),
        .dvsr    (yabs),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            yabs  <= '0;
            sq    <= 1'b0;
            sr    <= 1'b0;
            s     <= '0;
            r     <= '0;
        end else if (cancel_exc_ertn || !div) begin
            // s/r intentionally survive an abort; they only matter while complete is high.
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rem   <= '0;
                    quo   <= xabs_in;
                    yabs  <= yabs_in;
                    sq    <= xneg ^ yneg;
                    sr    <= xneg;
                    cnt   <= '0;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state <= S_DONE;
                        s     <= sq ? -quo_nxt : quo_nxt;
                        r     <= sr ? -rem_nxt[DATA_W-1:0] : rem_nxt[DATA_W-1:0];
                    end
                end
                S_DONE: begin
                    if (out_ack) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign complete = (state == S_DONE);
    assign busy     = (state == S_BUSY);

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: directed corner cases, stall/cancel/reset, random pairs.
// Expected results come from a 64-bit integer reference model.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cancel_exc_ertn;
    logic        div;
    logic        div_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic        out_ack;
    logic [31:0] s;
    logic [31:0] r;
    logic        complete;
    logic        busy;

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] r;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_iter dut (
        .clk             (clk),
        .resetn          (resetn),
        .cancel_exc_ertn (cancel_exc_ertn),
        .div             (div),
        .div_signed      (div_signed),
        .x               (x),
        .y               (y),
        .out_ack         (out_ack),
        .s               (s),
        .r               (r),
        .complete        (complete),
        .busy            (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
        res_t   res;
        longint as, bs, q, m;
        if (b == 32'd0) begin
            res.s = (sg && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            res.r = a;
        end else if (sg) begin
            as = longint'($signed(a));
            bs = longint'($signed(b));
            q  = as / bs;
            m  = as % bs;
            res.s = q[31:0];
            res.r = m[31:0];
        end else begin
            res.s = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    // Called at a negedge; returns at a negedge with the block back in IDLE.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sg, input int ack_dly, input bit keep, input bit scramble);
        res_t e;
        int   n;
        div        = 1'b1;
        x          = a;
        y          = b;
        div_signed = sg;
        exp_q.push_back(ref_div(a, b, sg));
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (scramble) begin
                x = $urandom;
                y = $urandom;
                div_signed = 1'($urandom);
            end
        end while (!complete && n < 100);
        e = exp_q.pop_front();
        if (!complete) begin
            check_eq({tag, "_timeout"}, 32'(n), 32'd33);
            div = 1'b0;
            return;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'd33);
        check_eq({tag, "_s"}, s, e.s);
        check_eq({tag, "_r"}, r, e.r);
        for (int i = 0; i < ack_dly; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack_dly >= 10) begin
                check_eq({tag, "_stall_cmp"}, 32'(complete), 32'd1);
                check_eq({tag, "_stall_s"}, s, e.s);
                check_eq({tag, "_stall_r"}, r, e.r);
            end
        end
        out_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ack = 1'b0;
        check_eq({tag, "_ack_idle"}, 32'(complete), 32'd0);
        if (!keep) div = 1'b0;
    endtask

    task automatic start_then_wait(input logic [31:0] a, input logic [31:0] b, input int cyc);
        div        = 1'b1;
        x          = a;
        y          = b;
        div_signed = 1'b0;
        repeat (cyc) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        resetn          = 1'b0;
        cancel_exc_ertn = 1'b0;
        div             = 1'b0;
        div_signed      = 1'b0;
        x               = '0;
        y               = '0;
        out_ack         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_s", s, 32'd0);
        check_eq("rst_r", r, 32'd0);
        check_eq("rst_complete", 32'(complete), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_div("u100_7",  32'd100,        32'd7,          1'b0, 0, 0, 0);
        run_div("sm7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 1, 0, 0);
        run_div("s7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 0, 0, 1);
        run_div("ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 2, 0, 0);
        run_div("u5_0",    32'd5,          32'd0,          1'b0, 0, 0, 0);
        run_div("sm5_0",   32'hFFFF_FFFB,  32'd0,          1'b1, 0, 0, 0);
        run_div("s5_0",    32'd5,          32'd0,          1'b1, 0, 0, 0);
        // Stall in DONE, then a back-to-back request with new operands.
        run_div("stall",   32'd1000,       32'd33,         1'b0, 10, 1, 0);
        run_div("b2b",     32'hFFFF_FF00,  32'd16,         1'b1, 0, 0, 0);

        // Cancel during BUSY; a fresh request follows the next cycle.
        start_then_wait(32'd100, 32'd7, 15);
        check_eq("cancel_busy_pre", 32'(busy), 32'd1);
        cancel_exc_ertn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel_exc_ertn = 1'b0;
        check_eq("cancel_busy", 32'(busy), 32'd0);
        check_eq("cancel_cmp", 32'(complete), 32'd0);
        run_div("post_cancel", 32'd9, 32'd3, 1'b0, 0, 0, 0);

        // Reset during BUSY clears the outputs.
        start_then_wait(32'd100, 32'd7, 15);
        resetn = 1'b0;
        div    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        check_eq("mrst_s", s, 32'd0);
        check_eq("mrst_r", r, 32'd0);
        check_eq("mrst_cmp", 32'(complete), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Random pairs, back-to-back where ack delay allows.
        for (int i = 0; i < 1200; i++) begin
            logic [31:0] a, b;
            int          k;
            a = $urandom;
            b = $urandom;
            k = $urandom_range(0, 9);
            if (k == 0) b = 32'd0;
            else if (k == 1) b = {28'd0, b[3:0]};
            else if (k == 2) b = 32'hFFFF_FFFF;
            else if (k == 3) a = 32'h8000_0000;
            else if (k == 4) b = {16'hFFFF, b[15:0]};
            run_div("rnd", a, b, 1'($urandom), $urandom_range(0, 5), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
